// File: rtl/sig_exp_scheduler.sv
// Round-robin sharing of one signal expansioner among N_CH rising-edge requesters.
// Launch one cycle after a request is queued; grant held for LAUNCH + (len+1) HOLD cycles; extra edges on a queued channel are dropped.
module sig_exp_scheduler #(
  parameter int N_CH                 = 4,
  parameter int CH_ID_WIDTH          = 2,
  parameter int MAX_EXTEND_LEN_WIDTH = 5,
  parameter int DEFAULT_LEN          = 4
) (
  input  logic                            CLK,
  input  logic                            RESETN,
  input  logic [N_CH-1:0]                 REQ,
  input  logic                            CFG_WE,
  input  logic [CH_ID_WIDTH-1:0]          CFG_ADDR,
  input  logic [MAX_EXTEND_LEN_WIDTH-1:0] CFG_DATA,
  output logic                            SIG_OUT,
  output logic [MAX_EXTEND_LEN_WIDTH-1:0] EXTEND_LEN,
  output logic [N_CH-1:0]                 GRANT,
  output logic [CH_ID_WIDTH-1:0]          GRANT_ID,
  output logic                            BUSY,
  output logic [N_CH-1:0]                 DROP
);

  typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} state_t;

  state_t                            state, state_nxt;
  logic [N_CH-1:0]                   req_d, pending, rise, clr;
  logic [MAX_EXTEND_LEN_WIDTH-1:0]   len_bank [N_CH];
  logic [MAX_EXTEND_LEN_WIDTH-1:0]   cnt, cnt_nxt;
  logic [CH_ID_WIDTH-1:0]            last_id, sel_id;
  logic                              sel_vld;

  assign rise = REQ & ~req_d;

  // First pending channel after the previous owner, wrapping at N_CH.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!sel_vld && pending[(int'(last_id) + 1 + k) % N_CH]) begin
        sel_vld = 1'b1;
        sel_id  = CH_ID_WIDTH'((int'(last_id) + 1 + k) % N_CH);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr       = '0;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          state_nxt = LAUNCH;
          clr       = N_CH'(1) << sel_id;
        end
      end
      LAUNCH: begin
        state_nxt = HOLD;
        cnt_nxt   = EXTEND_LEN;
      end
      HOLD: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= IDLE;
      cnt        <= '0;
      req_d      <= '0;
      pending    <= '0;
      last_id    <= CH_ID_WIDTH'(N_CH - 1);
      SIG_OUT    <= 1'b0;
      EXTEND_LEN <= '0;
      GRANT      <= '0;
      GRANT_ID   <= '0;
      BUSY       <= 1'b0;
      DROP       <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      req_d   <= REQ;
      // A rise coinciding with its own clear re-queues instead of dropping.
      pending <= (pending & ~clr) | rise;
      DROP    <= rise & pending & ~clr;
      SIG_OUT <= (state_nxt == LAUNCH);
      BUSY    <= (state_nxt != IDLE);
      if (state == IDLE && sel_vld) begin
        last_id    <= sel_id;
        GRANT_ID   <= sel_id;
        EXTEND_LEN <= len_bank[sel_id];
        GRANT      <= clr;
      end else if (state_nxt == IDLE) begin
        GRANT <= '0;
      end
    end
  end

  // Bank reads above see the pre-write value when a write shares the latch edge.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < N_CH; i++) len_bank[i] <= MAX_EXTEND_LEN_WIDTH'(DEFAULT_LEN);
    end else if (CFG_WE && (int'(CFG_ADDR) < N_CH)) begin
      len_bank[CFG_ADDR] <= CFG_DATA;
    end
  end

endmodule

// File: tb/tb_sig_exp_scheduler.sv
// Directed bench for sig_exp_scheduler: hand-computed grant order, window lengths and drop counts.
module tb_sig_exp_scheduler;
  localparam int N_CH = 4;
  localparam int R_ID = 0, R_LEN = 1, R_CYC = 2, R_GNT = 3, R_HOLD = 4;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [3:0] REQ = '0;
  logic       CFG_WE = 1'b0;
  logic [1:0] CFG_ADDR = '0;
  logic [4:0] CFG_DATA = '0;
  logic       SIG_OUT;
  logic [4:0] EXTEND_LEN;
  logic [3:0] GRANT;
  logic [1:0] GRANT_ID;
  logic       BUSY;
  logic [3:0] DROP;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int l_id[$], l_len[$], l_cyc[$], l_gnt[$], l_hold[$];
  int drop_cnt[N_CH];

  sig_exp_scheduler #(
    .N_CH(4), .CH_ID_WIDTH(2), .MAX_EXTEND_LEN_WIDTH(5), .DEFAULT_LEN(4)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .REQ(REQ), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
    .CFG_DATA(CFG_DATA), .SIG_OUT(SIG_OUT), .EXTEND_LEN(EXTEND_LEN), .GRANT(GRANT),
    .GRANT_ID(GRANT_ID), .BUSY(BUSY), .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  // Record every launch with its window length, and count DROP cycles per channel.
  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (RESETN) begin
      if (SIG_OUT) begin
        l_id.push_back(int'(GRANT_ID));
        l_len.push_back(int'(EXTEND_LEN));
        l_cyc.push_back(cyc);
        l_gnt.push_back(int'(GRANT));
        l_hold.push_back(0);
      end else if (BUSY && l_hold.size() > 0) begin
        l_hold[l_hold.size()-1] = l_hold[l_hold.size()-1] + 1;
      end
      for (int i = 0; i < N_CH; i++) if (DROP[i]) drop_cnt[i] = drop_cnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rec(input int sel, input int i);
    case (sel)
      R_ID:    return (i < l_id.size())   ? l_id[i]   : -1;
      R_LEN:   return (i < l_len.size())  ? l_len[i]  : -1;
      R_CYC:   return (i < l_cyc.size())  ? l_cyc[i]  : -1;
      R_GNT:   return (i < l_gnt.size())  ? l_gnt[i]  : -1;
      default: return (i < l_hold.size()) ? l_hold[i] : -1;
    endcase
  endfunction

  task automatic nclk();
    @(negedge CLK);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) nclk();
  endtask

  task automatic clear_mon();
    l_id.delete(); l_len.delete(); l_cyc.delete(); l_gnt.delete(); l_hold.delete();
    for (int i = 0; i < N_CH; i++) drop_cnt[i] = 0;
  endtask

  task automatic do_reset();
    nclk(); RESETN = 1'b0;
    nclk(); nclk(); RESETN = 1'b1;
  endtask

  task automatic cfg(input int a, input int d);
    nclk(); CFG_WE = 1'b1; CFG_ADDR = 2'(a); CFG_DATA = 5'(d);
    nclk(); CFG_WE = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] v);
    nclk(); REQ = v;
    nclk(); REQ = '0;
  endtask

  initial begin
    int exp_rr[6];
    logic [3:0] seq5[6];
    exp_rr = '{0, 1, 2, 3, 0, 3};
    seq5   = '{4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000};

    // Reset values
    nclk(); nclk();
    check("rst_sig_out", SIG_OUT, 0);
    check("rst_extend_len", EXTEND_LEN, 0);
    check("rst_grant", GRANT, 0);
    check("rst_grant_id", GRANT_ID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_drop", DROP, 0);
    RESETN = 1'b1;

    // Single request on channel 2 with the default length 4
    clear_mon();
    nclk(); REQ = 4'b0100;
    nclk(); check("t1_no_early_launch", SIG_OUT, 0); REQ = '0;
    nclk();
    check("t1_sig_out", SIG_OUT, 1);
    check("t1_grant", GRANT, 4'b0100);
    check("t1_grant_id", GRANT_ID, 2);
    check("t1_extend_len", EXTEND_LEN, 4);
    check("t1_busy", BUSY, 1);
    settle(12);
    check("t1_launches", l_id.size(), 1);
    check("t1_hold_cycles", rec(R_HOLD, 0), 5);
    check("t1_idle_busy", BUSY, 0);
    check("t1_idle_grant", GRANT, 0);
    check("t1_len_retained", EXTEND_LEN, 4);

    // Round-robin with zero-length windows, then wrap from last_id=3
    do_reset();
    for (int i = 0; i < N_CH; i++) cfg(i, 0);
    clear_mon();
    pulse(4'b1111); settle(15);
    pulse(4'b1001); settle(10);
    check("t2_launches", l_id.size(), 6);
    for (int i = 0; i < 6; i++) check("t2_order", rec(R_ID, i), exp_rr[i]);
    check("t2_onehot", rec(R_GNT, 1), 4'b0010);
    check("t2_spacing01", rec(R_CYC, 1) - rec(R_CYC, 0), 3);
    check("t2_spacing23", rec(R_CYC, 3) - rec(R_CYC, 2), 3);
    check("t2_hold_len0", rec(R_HOLD, 0), 1);
    check("t2_extend_len0", rec(R_LEN, 2), 0);

    // Length write during a window only affects later windows
    do_reset();
    cfg(1, 10);
    clear_mon();
    pulse(4'b0010);
    settle(3);
    cfg(1, 2);
    settle(20);
    pulse(4'b0010); settle(10);
    check("t3_launches", l_id.size(), 2);
    check("t3_len_first", rec(R_LEN, 0), 10);
    check("t3_hold_first", rec(R_HOLD, 0), 11);
    check("t3_len_second", rec(R_LEN, 1), 2);
    check("t3_hold_second", rec(R_HOLD, 1), 3);

    // Write on the same edge as the latch: old value wins
    cfg(3, 5);
    clear_mon();
    nclk(); REQ = 4'b1000;
    nclk(); REQ = '0; CFG_WE = 1'b1; CFG_ADDR = 2'd3; CFG_DATA = 5'd7;
    nclk(); CFG_WE = 1'b0;
    settle(15);
    pulse(4'b1000); settle(15);
    check("t3b_launches", l_id.size(), 2);
    check("t3b_len_old", rec(R_LEN, 0), 5);
    check("t3b_len_new", rec(R_LEN, 1), 7);

    // Second rise on an already pending channel is dropped
    do_reset();
    cfg(0, 6);
    clear_mon();
    nclk(); REQ = 4'b0001;
    nclk(); REQ = '0;
    nclk(); REQ = 4'b0010;
    nclk(); REQ = '0;
    nclk(); REQ = 4'b0010;
    nclk(); REQ = '0;
    settle(25);
    check("t4_drop_ch1", drop_cnt[1], 1);
    check("t4_drop_ch0", drop_cnt[0], 0);
    check("t4_launches", l_id.size(), 2);
    check("t4_first", rec(R_ID, 0), 0);
    check("t4_second", rec(R_ID, 1), 1);

    // Rise on channel 2 exactly on its arbitration edge is re-queued
    do_reset();
    cfg(0, 0);
    clear_mon();
    for (int i = 0; i < 6; i++) begin
      nclk(); REQ = seq5[i];
    end
    settle(25);
    check("t5_launches", l_id.size(), 3);
    check("t5_id0", rec(R_ID, 0), 0);
    check("t5_id1", rec(R_ID, 1), 2);
    check("t5_id2", rec(R_ID, 2), 2);
    check("t5_spacing", rec(R_CYC, 1) - rec(R_CYC, 0), 3);
    check("t5_no_drop", drop_cnt[2], 0);

    // Asynchronous reset mid-window discards queued requests
    do_reset();
    clear_mon();
    nclk(); REQ = 4'b0001;
    nclk(); REQ = 4'b0010;
    nclk(); REQ = '0;
    nclk(); nclk();
    check("t6_pre_busy", BUSY, 1);
    check("t6_pre_grant", GRANT, 4'b0001);
    RESETN = 1'b0;
    #1;
    check("t6_async_sig_out", SIG_OUT, 0);
    check("t6_async_grant", GRANT, 0);
    check("t6_async_busy", BUSY, 0);
    nclk(); RESETN = 1'b1;
    clear_mon();
    settle(15);
    check("t6_no_grant_after", l_id.size(), 0);

    // REQ held high through reset release counts as exactly one request
    nclk(); RESETN = 1'b0; REQ = 4'b0010;
    nclk(); nclk(); RESETN = 1'b1;
    clear_mon();
    settle(12);
    REQ = '0;
    settle(10);
    check("t6_held_launches", l_id.size(), 1);
    check("t6_held_id", rec(R_ID, 0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
